// File: rtl/alu_pkg.sv
// Shared definitions for the 6-bit ALU and its accumulator issue stage:
// datapath widths, ALU control codes, command kinds and sequencer states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH  = 6;
    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned SEQ_CNT_W  = 8;

    localparam logic [ALU_CTRL_W-1:0] CTRL_AND  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] CTRL_OR   = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] CTRL_ADD  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLL  = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] CTRL_XOR  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SUB  = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SRA  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLT  = 4'b1000;
    // Undefined code: the ALU outputs 0 for it, so it is used as the idle drive.
    localparam logic [ALU_CTRL_W-1:0] CTRL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        KIND_LOAD  = 2'b00,
        KIND_EXEC  = 2'b01,
        KIND_CLEAR = 2'b10,
        KIND_RSVD  = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_acc_sequencer.sv
// Issue stage for the combinational ALU: accepts one command at a time, drives
// the ALU for one cycle, captures the result into the accumulator and responds.
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = ALU_WIDTH,
    parameter int unsigned CTRL_W = ALU_CTRL_W,
    parameter int unsigned CNT_W  = SEQ_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [CTRL_W-1:0] cmd_ctrl,
    input  logic [WIDTH-1:0]  cmd_operand,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic              res_err,
    output logic [WIDTH-1:0]  acc_q,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [CTRL_W-1:0] IDLE_CTRL = {CTRL_W{1'b1}};

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [WIDTH-1:0]    acc_d;
    logic                rdy_q, rdy_d;
    logic                res_valid_q, res_valid_d;
    logic [WIDTH-1:0]    res_data_q, res_data_d;
    logic                res_carry_q, res_carry_d;
    logic                res_zero_q, res_zero_d;
    logic                res_err_q, res_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            kind_q      <= KIND_LOAD;
            ctrl_q      <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            rdy_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
            cnt_q       <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= IDLE_CTRL;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            ctrl_q      <= ctrl_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            rdy_q       <= rdy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
            cnt_q       <= cnt_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        ctrl_d      = ctrl_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        res_err_d   = res_err_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && rdy_q) begin
                    kind_d  = kind_e'(cmd_kind);
                    ctrl_d  = cmd_ctrl;
                    opnd_d  = cmd_operand;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d     = S_RESP;
                res_carry_d = 1'b0;
                res_err_d   = 1'b0;
                case (kind_q)
                    KIND_EXEC: begin
                        acc_d       = alu_out;
                        res_data_d  = alu_out;
                        res_carry_d = alu_carry;
                        res_zero_d  = alu_zero;
                    end
                    KIND_LOAD: begin
                        acc_d      = opnd_q;
                        res_data_d = opnd_q;
                        res_zero_d = (opnd_q == '0);
                    end
                    KIND_CLEAR: begin
                        acc_d      = '0;
                        res_data_d = '0;
                        res_zero_d = 1'b1;
                    end
                    default: begin
                        // Reserved kind reports the untouched accumulator with an error.
                        res_data_d = acc_q;
                        res_zero_d = (acc_q == '0);
                        res_err_d  = 1'b1;
                    end
                endcase
            end
            S_RESP: begin
                if (res_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered handshake and ALU drive follow the upcoming state.
        rdy_d       = (state_d == S_IDLE);
        res_valid_d = (state_d == S_RESP);
        alu_b_d     = '0;
        alu_ctrl_d  = IDLE_CTRL;
        if (state_d == S_ISSUE && kind_d == KIND_EXEC) begin
            alu_b_d    = opnd_d;
            alu_ctrl_d = ctrl_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign alu_a     = acc_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Self-checking bench for alu_acc_sequencer with a behavioural 6-bit ALU attached.
module tb_alu_acc_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_kind;
    logic [3:0] cmd_ctrl;
    logic [5:0] cmd_operand;
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic [3:0] alu_ctrl;
    logic [5:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_err;
    logic [5:0] acc_q;
    logic [7:0] op_count;

    alu_acc_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_ctrl(cmd_ctrl), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err),
        .acc_q(acc_q), .op_count(op_count)
    );

    // Stand-in for the combinational ALU; carry on SUB is the borrow.
    always_comb begin
        alu_out   = 6'd0;
        alu_carry = 1'b0;
        case (alu_ctrl)
            CTRL_AND: alu_out = alu_a & alu_b;
            CTRL_OR:  alu_out = alu_a | alu_b;
            CTRL_XOR: alu_out = alu_a ^ alu_b;
            CTRL_ADD: {alu_carry, alu_out} = 7'({1'b0, alu_a}) + 7'({1'b0, alu_b});
            CTRL_SUB: begin
                alu_out   = alu_a - alu_b;
                alu_carry = (alu_a < alu_b);
            end
            CTRL_SLL: alu_out = alu_a << alu_b[2:0];
            CTRL_SRA: alu_out = 6'($signed(alu_a) >>> alu_b[2:0]);
            CTRL_SLT: alu_out = {5'd0, ($signed(alu_a) < $signed(alu_b))};
            default:  alu_out = 6'd0;
        endcase
        alu_zero = (alu_out == 6'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [5:0] data;
        logic       carry;
        logic       zero;
        logic       err;
    } exp_t;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] ctrl;
        logic [5:0] opnd;
        exp_t       exp;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       got;
    vec_t       vecs[15];
    int         checks   = 0;
    int         failures = 0;
    logic [5:0] model_acc = 6'd0;
    int         last_acc_cyc = 0;
    int         first_cyc = 0;

    function automatic exp_t mk(input logic [5:0] d, input logic c, input logic z, input logic e);
        exp_t r;
        r.data = d; r.carry = c; r.zero = z; r.err = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Response scoreboard: compare on every response handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=0x%0h required=none t=%0t", res_data, $time);
            end else begin
                got = exp_q.pop_front();
                chk("res_data",  32'(res_data),  32'(got.data));
                chk("res_carry", 32'(res_carry), 32'(got.carry));
                chk("res_zero",  32'(res_zero),  32'(got.zero));
                chk("res_err",   32'(res_err),   32'(got.err));
                chk("acc_q",     32'(acc_q),     32'(got.data));
            end
        end
    end

    // Offer a command, wait for acceptance, then check the ALU drive during ISSUE.
    task automatic do_cmd(input logic [1:0] kind, input logic [3:0] ctrl,
                          input logic [5:0] opnd, input exp_t e);
        bit ok = 1'b0;
        cmd_kind    = kind;
        cmd_ctrl    = ctrl;
        cmd_operand = opnd;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            fail_now("accept_timeout");
            return;
        end
        last_acc_cyc = cyc;
        exp_q.push_back(e);
        chk("issue_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("issue_alu_a", 32'(alu_a), 32'(model_acc));
        chk("issue_alu_b", 32'(alu_b), (kind == KIND_EXEC) ? 32'(opnd) : 32'd0);
        chk("issue_alu_ctrl", 32'(alu_ctrl), (kind == KIND_EXEC) ? 32'(ctrl) : 32'hF);
        model_acc = e.data;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0 && !res_valid) break;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0 || res_valid) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{KIND_LOAD,  4'h0,     6'h15, mk(6'h15, 1'b0, 1'b0, 1'b0)};
        vecs[1]  = '{KIND_EXEC,  CTRL_ADD, 6'h2B, mk(6'h00, 1'b1, 1'b1, 1'b0)};
        vecs[2]  = '{KIND_LOAD,  4'h0,     6'h05, mk(6'h05, 1'b0, 1'b0, 1'b0)};
        vecs[3]  = '{KIND_EXEC,  CTRL_SUB, 6'h07, mk(6'h3E, 1'b1, 1'b0, 1'b0)};
        vecs[4]  = '{KIND_LOAD,  4'h0,     6'h07, mk(6'h07, 1'b0, 1'b0, 1'b0)};
        vecs[5]  = '{KIND_EXEC,  CTRL_SUB, 6'h05, mk(6'h02, 1'b0, 1'b0, 1'b0)};
        vecs[6]  = '{KIND_LOAD,  4'h0,     6'h09, mk(6'h09, 1'b0, 1'b0, 1'b0)};
        vecs[7]  = '{KIND_RSVD,  CTRL_ADD, 6'h2A, mk(6'h09, 1'b0, 1'b0, 1'b1)};
        vecs[8]  = '{KIND_CLEAR, 4'h0,     6'h33, mk(6'h00, 1'b0, 1'b1, 1'b0)};
        vecs[9]  = '{KIND_LOAD,  4'h0,     6'h00, mk(6'h00, 1'b0, 1'b1, 1'b0)};
        vecs[10] = '{KIND_RSVD,  4'h0,     6'h11, mk(6'h00, 1'b0, 1'b1, 1'b1)};
        vecs[11] = '{KIND_LOAD,  4'h0,     6'h3F, mk(6'h3F, 1'b0, 1'b0, 1'b0)};
        vecs[12] = '{KIND_EXEC,  CTRL_XOR, 6'h15, mk(6'h2A, 1'b0, 1'b0, 1'b0)};
        vecs[13] = '{KIND_EXEC,  CTRL_OR,  6'h01, mk(6'h2B, 1'b0, 1'b0, 1'b0)};
        vecs[14] = '{KIND_EXEC,  CTRL_ADD, 6'h01, mk(6'h2C, 1'b0, 1'b0, 1'b0)};

        cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_ctrl = 4'h0; cmd_operand = 6'h00;
        res_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_acc",       32'(acc_q),     32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        chk("rst_alu_ctrl",  32'(alu_ctrl),  32'hF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("release_rdy_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("release_rdy_high", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_cmd(vecs[i].kind, vecs[i].ctrl, vecs[i].opnd, vecs[i].exp);
        end
        drain();
        chk("table_op_count", 32'(op_count), 32'd15);

        // Backpressure on the response with a command offered meanwhile.
        do_cmd(KIND_LOAD, 4'h0, 6'h3C, mk(6'h3C, 1'b0, 1'b0, 1'b0));
        drain();
        res_ready = 1'b0;
        do_cmd(KIND_EXEC, CTRL_AND, 6'h0F, mk(6'h0C, 1'b0, 1'b0, 1'b0));
        cmd_kind = KIND_LOAD; cmd_ctrl = 4'h0; cmd_operand = 6'h11; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_res_data",  32'(res_data),  32'h0C);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rdy_after_hs",   32'(cmd_ready), 32'd1);
        chk("bp_valid_after_hs", 32'(res_valid), 32'd0);
        chk("bp_data_held",      32'(res_data),  32'h0C);
        exp_q.push_back(mk(6'h11, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_accepted", 32'(cmd_ready), 32'd0);
        model_acc = 6'h11;
        drain();
        chk("bp_op_count", 32'(op_count), 32'd18);

        // Reset while an EXEC is in ISSUE: no response may follow.
        cmd_kind = KIND_EXEC; cmd_ctrl = CTRL_ADD; cmd_operand = 6'h01; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid_in_issue", 32'(alu_ctrl), 32'(CTRL_ADD));
        rst_n = 1'b0;
        #1;
        chk("mid_res_valid", 32'(res_valid), 32'd0);
        chk("mid_res_data",  32'(res_data),  32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_acc",       32'(acc_q),     32'd0);
        chk("mid_op_count",  32'(op_count),  32'd0);
        chk("mid_alu_ctrl",  32'(alu_ctrl),  32'hF);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rdy",      32'(cmd_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("post_res_valid", 32'(res_valid), 32'd0);
        chk("post_op_count",  32'(op_count),  32'd0);
        model_acc = 6'h00;

        // Counter wrap and back-to-back throughput.
        for (int i = 0; i < 255; i++) begin
            do_cmd(KIND_LOAD, 4'h0, 6'(i), mk(6'(i), 1'b0, (6'(i) == 6'd0), 1'b0));
            if (i == 0) first_cyc = last_acc_cyc;
        end
        chk("throughput", 32'(last_acc_cyc - first_cyc), 32'd762);
        drain();
        chk("cnt_255", 32'(op_count), 32'd255);
        do_cmd(KIND_LOAD, 4'h0, 6'h2D, mk(6'h2D, 1'b0, 1'b0, 1'b0));
        drain();
        chk("cnt_wrap", 32'(op_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
